// File: rtl/sqrt_arbiter.sv
// Round-robin front end sharing one cordic_sqrt core between N_REQ
// requesters, with a watchdog on the core and a sticky fault flag.
module sqrt_arbiter #(
    parameter int N_REQ     = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = IN_WIDTH / 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*IN_WIDTH-1:0] req_x,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [OUT_WIDTH-1:0]      rsp_y,
    output logic                      rsp_neg,
    output logic                      rsp_err,
    output logic                      core_start,
    output logic [IN_WIDTH-1:0]       core_x,
    input  logic [OUT_WIDTH-1:0]      core_y,
    input  logic                      core_done,
    input  logic                      core_is_neg,
    output logic                      busy,
    output logic                      fault,
    input  logic                      fault_clr
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [N_REQ-1:0] ONE = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t               state_q;
    logic [GW-1:0]        rr_q;
    logic [GW-1:0]        grant_q;
    logic [CW-1:0]        cnt_q;
    logic [N_REQ-1:0]     rsp_valid_q;
    logic [OUT_WIDTH-1:0] rsp_y_q;
    logic                 rsp_neg_q;
    logic                 rsp_err_q;
    logic                 core_start_q;
    logic [IN_WIDTH-1:0]  core_x_q;
    logic                 fault_q;

    logic                 win_vld;
    logic [GW-1:0]        win_idx;
    logic                 accept;

    // Scan downwards so the lowest offset from rr_q is the last to write.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % N_REQ;
            if (req_valid[idx]) begin
                win_vld = 1'b1;
                win_idx = GW'(idx);
            end
        end
    end

    assign accept    = (state_q == IDLE) && !fault_q && win_vld;
    assign req_ready = (accept && rst_n) ? (ONE << win_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_y_q      <= '0;
            rsp_neg_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
            core_start_q <= 1'b0;
            core_x_q     <= '0;
            fault_q      <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            // A timeout later in this block overrides a coincident clear.
            if (fault_clr) begin
                fault_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        core_x_q     <= req_x[int'(win_idx)*IN_WIDTH +: IN_WIDTH];
                        grant_q      <= win_idx;
                        core_start_q <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (core_done) begin
                        rsp_y_q     <= core_y;
                        rsp_neg_q   <= core_is_neg;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= ONE << grant_q;
                        state_q     <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_y_q     <= '0;
                        rsp_neg_q   <= 1'b0;
                        rsp_err_q   <= 1'b1;
                        fault_q     <= 1'b1;
                        rsp_valid_q <= ONE << grant_q;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_q]) begin
                        rsp_valid_q <= '0;
                        rr_q        <= (grant_q == GW'(N_REQ - 1)) ?
                                       '0 : grant_q + GW'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_neg    = rsp_neg_q;
    assign rsp_err    = rsp_err_q;
    assign core_start = core_start_q;
    assign core_x     = core_x_q;
    assign busy       = (state_q != IDLE);
    assign fault      = fault_q;

endmodule
